// File: rtl/lsu.sv
// Load/store unit: the memory phase of the multi-cycle RV32I core. Runs one
// ready-handshake bus access per instruction and aligns/extends load data.
module lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  state,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_result,
  output logic        stall,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} fsm_t;

  fsm_t        fsm, fsm_next;
  logic        is_mem, start, illegal, misaligned, timeout_hit;
  logic [31:0] tcnt;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        load_q;
  logic [3:0]  strb;
  logic [31:0] wdata, shifted, load_ext;

  assign is_mem = is_load | is_store;
  assign start  = (fsm == IDLE) && (state == 3'd3) && is_mem;

  always_comb begin
    if (is_load) illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    else         illegal = funct3[2] || (funct3[1:0] == 2'b11);
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
  end

  // tcnt counts completed wait cycles, so the limit fires on the TIMEOUT_CYCLES-th
  // BUS cycle without ready; a ready in that same cycle still wins.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((tcnt + 32'd1) == TIMEOUT_CYCLES);

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        wdata = {4{store_data[7:0]}};
        strb  = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        wdata = {2{store_data[15:0]}};
        strb  = 4'b0011 << addr[1:0];
      end
      default: begin
        wdata = store_data;
        strb  = '1;
      end
    endcase
  end

  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_ext = {24'd0, shifted[7:0]};
      3'b101:  load_ext = {16'd0, shifted[15:0]};
      default: load_ext = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_next;
  end

  always_comb begin
    fsm_next = fsm;
    case (fsm)
      IDLE: if (start) fsm_next = (illegal || misaligned) ? DONE : BUS;
      BUS:  if (mem_ready || timeout_hit) fsm_next = DONE;
      DONE: if (state != 3'd3) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  always_comb begin
    stall = (state == 3'd3) && is_mem && (fsm != DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_wstrb   <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      load_result <= '0;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
      tcnt        <= '0;
      off_q       <= '0;
      f3_q        <= '0;
      load_q      <= 1'b0;
    end else if (start) begin
      off_q       <= addr[1:0];
      f3_q        <= funct3;
      load_q      <= is_load;
      fault       <= 1'b0;
      fault_cause <= 2'b00;
      tcnt        <= '0;
      if (illegal) begin
        fault       <= 1'b1;
        fault_cause <= 2'b10;
      end else if (misaligned) begin
        fault       <= 1'b1;
        fault_cause <= 2'b01;
      end else begin
        mem_req   <= 1'b1;
        mem_addr  <= {addr[31:2], 2'b00};
        mem_we    <= ~is_load;
        mem_wstrb <= is_load ? 4'b0000 : strb;
        mem_wdata <= wdata;
      end
    end else if (fsm == BUS) begin
      if (mem_ready) begin
        mem_req   <= 1'b0;
        mem_wstrb <= '0;
        if (load_q) load_result <= load_ext;
      end else if (timeout_hit) begin
        mem_req     <= 1'b0;
        fault       <= 1'b1;
        fault_cause <= 2'b11;
      end else begin
        tcnt <= tcnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: per-cycle timeline model derived from each
// access's legality and wait count, plus literal pins for known vectors.
module tb_lsu;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  state;
  logic        is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic [31:0] load_result;
  logic        stall, fault;
  logic [1:0]  fault_cause;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ready;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .state(state), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data), .load_result(load_result),
    .stall(stall), .fault(fault), .fault_cause(fault_cause), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int n_checks = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  logic        e_req, e_stall, e_bus, e_wz, e_we;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_wstrb;
  logic        m_fault;
  logic [1:0]  m_cause;
  logic [31:0] m_lr;

  logic        pin_en, pin_we;
  logic [31:0] pin_addr, pin_wdata;
  logic [3:0]  pin_wstrb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_legal(input logic ld, input logic [2:0] f3);
    if (ld) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return f3 <= 3'd2;
  endfunction

  function automatic int m_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
    longint v;
    longint by[4];
    for (int i = 0; i < 4; i++) by[i] = longint'(rd[8*i +: 8]);
    case (m_size(f3))
      1: begin
        v = by[off];
        if (!f3[2] && v >= 128) v = v - 256;
      end
      2: begin
        v = by[off] + 256 * by[off+1];
        if (!f3[2] && v >= 32768) v = v - 65536;
      end
      default: v = by[0] + 256 * by[1] + 65536 * by[2] + 16777216 * by[3];
    endcase
    return 32'(v);
  endfunction

  function automatic logic [3:0] m_strb(input logic ld, input logic [2:0] f3, input int off);
    logic [3:0] s;
    int sz;
    s = '0;
    sz = m_size(f3);
    if (!ld)
      for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + sz);
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    int sz;
    sz = m_size(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
    return w;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("stall", 32'(stall), 32'(e_stall));
      chk("fault", 32'(fault), 32'(m_fault));
      chk("fault_cause", 32'(fault_cause), 32'(m_cause));
      chk("load_result", load_result, m_lr);
      if (e_bus) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_wstrb", 32'(mem_wstrb), 32'(e_wstrb));
        if (e_we) chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (e_wz) chk("wstrb_clear", 32'(mem_wstrb), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] non_mem_state();
    logic [2:0] s;
    s = 3'($urandom_range(0, 6));
    if (s >= 3'd3) s = s + 3'd1;
    return s;
  endfunction

  task automatic do_access(input logic ld, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [31:0] rd,
                           input int w, input int hold, input int gap);
    int off, n;
    logic to, ok;
    off = int'(a[1:0]);
    step();
    state = 3'd3; is_load = ld; is_store = ~ld; funct3 = f3; addr = a; store_data = sd;
    mem_rdata = $urandom; mem_ready = 1'($urandom_range(0, 1));
    e_stall = 1'b1; e_req = 1'b0; e_bus = 1'b0; e_wz = 1'b0;
    ok = m_legal(ld, f3) && ((off % m_size(f3)) == 0);
    if (!ok) begin
      step();
      mem_ready = 1'($urandom_range(0, 1));
      e_stall = 1'b0;
      m_fault = 1'b1;
      m_cause = m_legal(ld, f3) ? 2'd1 : 2'd2;
    end else begin
      to = (w >= T);
      n = to ? T : w + 1;
      e_addr = {a[31:2], 2'b00}; e_we = ~ld;
      e_wstrb = m_strb(ld, f3, off); e_wdata = m_wdata(f3, sd);
      for (int k = 1; k <= n; k++) begin
        step();
        e_req = 1'b1; e_bus = 1'b1; m_fault = 1'b0; m_cause = 2'd0;
        mem_ready = !to && (k == n);
        mem_rdata = (k == n) ? rd : $urandom;
        if (pin_en && k == 1) begin
          #2;
          chk("pin_addr", mem_addr, pin_addr);
          chk("pin_we", 32'(mem_we), 32'(pin_we));
          chk("pin_wstrb", 32'(mem_wstrb), 32'(pin_wstrb));
          if (pin_we) chk("pin_wdata", mem_wdata, pin_wdata);
        end
      end
      step();
      e_req = 1'b0; e_bus = 1'b0; e_stall = 1'b0;
      mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      if (to) begin
        m_fault = 1'b1; m_cause = 2'd3;
      end else begin
        e_wz = 1'b1;
        if (ld) m_lr = m_load(f3, off, rd);
      end
    end
    repeat (hold) begin
      step();
      e_wz = 1'b0; mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    end
    repeat (gap) begin
      step();
      e_wz = 1'b0; state = non_mem_state();
      is_load = 1'($urandom_range(0, 1)); is_store = 1'($urandom_range(0, 1));
      funct3 = 3'($urandom_range(0, 7)); addr = $urandom;
      mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    end
    pin_en = 1'b0;
  endtask

  task automatic rand_access();
    logic ld;
    logic [2:0] f3;
    int w;
    logic [2:0] lut[5];
    lut = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    ld = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) != 0) f3 = ld ? lut[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
    else                           f3 = 3'($urandom_range(0, 7));
    w = ($urandom_range(0, 4) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
    do_access(ld, f3, $urandom, $urandom, $urandom, w,
              int'($urandom_range(0, 2)), int'($urandom_range(1, 2)));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; state = 3'd0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = '0; store_data = '0; mem_rdata = '0; mem_ready = 1'b0;
    pin_en = 1'b0; pin_we = 1'b0; pin_addr = '0; pin_wdata = '0; pin_wstrb = '0;
    e_req = 1'b0; e_stall = 1'b0; e_bus = 1'b0; e_wz = 1'b0; e_we = 1'b0;
    e_addr = '0; e_wdata = '0; e_wstrb = '0;
    m_fault = 1'b0; m_cause = 2'd0; m_lr = '0;
    #3;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_load_result", load_result, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_fault_cause", 32'(fault_cause), 32'd0);
    step();
    rst_n = 1'b1;
    chk_en = 1'b1;

    pin_en = 1'b1; pin_addr = 32'h100; pin_we = 1'b0; pin_wstrb = 4'b0000;
    do_access(1'b1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 1);
    chk("lw_literal", load_result, 32'hDEADBEEF);
    do_access(1'b1, 3'b000, 32'h203, 32'h0, 32'h80FF1234, 0, 0, 1);
    chk("lb_literal", load_result, 32'hFFFFFF80);
    do_access(1'b1, 3'b100, 32'h203, 32'h0, 32'h80FF1234, 1, 0, 1);
    chk("lbu_literal", load_result, 32'h00000080);
    do_access(1'b1, 3'b101, 32'h202, 32'h0, 32'h80FF1234, 2, 0, 1);
    chk("lhu_literal", load_result, 32'h000080FF);
    pin_en = 1'b1; pin_addr = 32'h300; pin_we = 1'b1; pin_wstrb = 4'b1100; pin_wdata = 32'hABCDABCD;
    do_access(1'b0, 3'b001, 32'h302, 32'h0000ABCD, 32'h12345678, 3, 0, 1);
    chk("sh_keeps_load_result", load_result, 32'h000080FF);
    do_access(1'b1, 3'b010, 32'h101, 32'h0, 32'h0, 0, 1, 1);
    chk("misalign_fault", 32'(fault), 32'd1);
    chk("misalign_cause", 32'(fault_cause), 32'd1);
    do_access(1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0, 1);
    chk("illegal_cause", 32'(fault_cause), 32'd2);
    do_access(1'b1, 3'b010, 32'h500, 32'h0, 32'h11111111, 10, 1, 2);
    chk("timeout_fault", 32'(fault), 32'd1);
    chk("timeout_cause", 32'(fault_cause), 32'd3);
    chk("timeout_keeps_load_result", load_result, 32'h000080FF);
    do_access(1'b0, 3'b000, 32'h601, 32'h0000005A, 32'h0, 0, 0, 1);
    chk("fault_cleared", 32'(fault), 32'd0);

    for (int i = 0; i < 200; i++) rand_access();

    step();
    state = 3'd3; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h400; mem_ready = 1'b0;
    e_stall = 1'b1; e_req = 1'b0; e_bus = 1'b0; e_wz = 1'b0;
    step();
    e_req = 1'b1; e_bus = 1'b1; e_addr = 32'h400; e_we = 1'b0; e_wstrb = 4'b0000;
    m_fault = 1'b0; m_cause = 2'd0;
    step();
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_async_mem_req", 32'(mem_req), 32'd0);
    state = 3'd0; is_load = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    m_lr = '0; m_fault = 1'b0; m_cause = 2'd0;
    e_req = 1'b0; e_stall = 1'b0; e_bus = 1'b0;
    chk("rst_mid_bus_load_result", load_result, 32'd0);
    chk("rst_mid_bus_fault", 32'(fault), 32'd0);
    chk_en = 1'b1;

    for (int i = 0; i < 20; i++) rand_access();

    step();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
